// File: rtl/worm_cmd_seq_pkg.sv
// Shared types and constants for the worm command path.
// The worm position stage imports the same package.
package worm_cmd_seq_pkg;

    localparam int DIR_W   = 2;
    localparam int STEP_W  = 2;
    localparam int REP_W   = 3;
    localparam int CMD_W   = 4;
    localparam int ENTRY_W = DIR_W + STEP_W + REP_W;

    // dir[1] selects subtract (S/W), dir[0] selects the E/W axis
    localparam logic [DIR_W-1:0] DIR_N = 2'b00;
    localparam logic [DIR_W-1:0] DIR_E = 2'b01;
    localparam logic [DIR_W-1:0] DIR_S = 2'b10;
    localparam logic [DIR_W-1:0] DIR_W_ = 2'b11;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'b0000;

    typedef enum logic {
        IDLE,
        ISSUE
    } seq_state_t;

    typedef struct packed {
        logic [DIR_W-1:0]  dir;
        logic [STEP_W-1:0] step;
        logic [REP_W-1:0]  rep;
    } move_t;

    function automatic logic [CMD_W-1:0] move_cmd(input move_t m);
        return {m.dir, m.step};
    endfunction

endpackage

// File: rtl/worm_cmd_seq_if.sv
// Upstream move handshake: valid/ready plus the move fields.
interface worm_cmd_seq_if;
    import worm_cmd_seq_pkg::*;

    logic              push_valid;
    logic              push_ready;
    logic [DIR_W-1:0]  push_dir;
    logic [STEP_W-1:0] push_step;
    logic [REP_W-1:0]  push_rep;

    modport master (
        output push_valid, push_dir, push_step, push_rep,
        input  push_ready
    );

    modport slave (
        input  push_valid, push_dir, push_step, push_rep,
        output push_ready
    );

endinterface

// File: rtl/worm_cmd_fifo.sv
// Synchronous move FIFO; no bypass, so a push into an empty FIFO pops one edge later.
module worm_cmd_fifo
    import worm_cmd_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  move_t      din,
    input  logic       pop,
    output move_t      head,
    output logic [4:0] count,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    move_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 5'(DEPTH));
    assign empty   = (count == 5'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/worm_cmd_seq.sv
// Move sequencer: expands queued {dir,step,rep} moves into rep+1 registered worm commands.
module worm_cmd_seq
    import worm_cmd_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    worm_cmd_seq_if.slave    push,
    input  logic             pause,
    output logic [CMD_W-1:0] cmd_out,
    output logic             cmd_active,
    output logic [4:0]       fifo_count
);

    seq_state_t       state, next_state;
    logic [CMD_W-1:0] cur_cmd, next_cur_cmd;
    logic [REP_W-1:0] rem, next_rem;
    logic [CMD_W-1:0] next_cmd_out;
    logic             next_active;
    logic             pop;
    move_t            head;
    logic             full;
    logic             empty;

    worm_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push.push_valid),
        .din   ({push.push_dir, push.push_step, push.push_rep}),
        .pop   (pop),
        .head  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign push.push_ready = !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_cmd    <= CMD_NOP;
            rem        <= '0;
            cmd_out    <= CMD_NOP;
            cmd_active <= 1'b0;
        end else begin
            state      <= next_state;
            cur_cmd    <= next_cur_cmd;
            rem        <= next_rem;
            cmd_out    <= next_cmd_out;
            cmd_active <= next_active;
        end
    end

    // Pause freezes everything but still emits a no-op so the worm holds still
    always_comb begin
        next_state   = state;
        next_cur_cmd = cur_cmd;
        next_rem     = rem;
        next_cmd_out = CMD_NOP;
        next_active  = 1'b0;
        pop          = 1'b0;
        if (!pause) begin
            if (state == ISSUE && rem != '0) begin
                next_cmd_out = cur_cmd;
                next_active  = 1'b1;
                next_rem     = rem - 1'b1;
            end else if (!empty) begin
                pop          = 1'b1;
                next_cur_cmd = move_cmd(head);
                next_cmd_out = move_cmd(head);
                next_rem     = head.rep;
                next_active  = 1'b1;
                next_state   = ISSUE;
            end else begin
                next_state   = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_worm_cmd_seq.sv
// Randomized and directed bench for worm_cmd_seq against a queue-based reference model.
module tb_worm_cmd_seq;
    import worm_cmd_seq_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       pause;
    logic [3:0] cmd_out;
    logic       cmd_active;
    logic [4:0] fifo_count;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: queued moves, plus the expanded list of commands still owed
    logic [6:0] q    [$];
    logic [3:0] pend [$];
    logic [3:0] exp_out;
    logic       exp_act;

    logic [10:0] obs;
    logic [10:0] exp_v;

    worm_cmd_seq_if push_if ();

    worm_cmd_seq #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push_if.slave),
        .pause      (pause),
        .cmd_out    (cmd_out),
        .cmd_active (cmd_active),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic v, input logic [6:0] e, input logic p, input logic rs);
        logic       acc;
        logic [6:0] h;
        if (rs) begin
            q.delete();
            pend.delete();
            exp_out = 4'b0000;
            exp_act = 1'b0;
            return;
        end
        acc = v && (q.size() != DEPTH);
        exp_out = 4'b0000;
        exp_act = 1'b0;
        if (!p) begin
            if (pend.size() == 0 && q.size() > 0) begin
                h = q.pop_front();
                for (int i = 0; i <= int'(h[2:0]); i++) pend.push_back(h[6:3]);
            end
            if (pend.size() > 0) begin
                exp_out = pend.pop_front();
                exp_act = 1'b1;
            end
        end
        if (acc) q.push_back(e);
    endtask

    task automatic tick(input logic v, input logic [1:0] d, input logic [1:0] s,
                        input logic [2:0] r, input logic p, input logic rs);
        push_if.push_valid = v;
        push_if.push_dir   = d;
        push_if.push_step  = s;
        push_if.push_rep   = r;
        pause              = p;
        rst                = rs;
        @(posedge clk);
        model_edge(v, {d, s, r}, p, rs);
        #1;
        obs = {cmd_out, cmd_active, fifo_count, push_if.push_ready};
    endtask

    function automatic logic [10:0] expected_vec();
        return {exp_out, exp_act, 5'(q.size()), q.size() != DEPTH};
    endfunction

    task automatic test_reset();
        tick(1'b0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b1);
        tick(1'b0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
        vectors++;
        if (obs !== 11'b0000_0_00000_1) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: got %b expected %b", obs, 11'b0000_0_00000_1);
        end
        exp_v = expected_vec();
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL reset_model: got %b expected %b", obs, exp_v);
        end
    endtask

    task automatic test_single_move();
        for (int c = 0; c < 6; c++) begin
            tick(c == 0, DIR_E, 2'd3, 3'd2, 1'b0, 1'b0);
            exp_v = expected_vec();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL single_move cyc %0d: got %b expected %b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] d [3] = '{DIR_N, DIR_S, DIR_W_};
        logic [1:0] s [3] = '{2'd1, 2'd2, 2'd3};
        logic [2:0] r [3] = '{3'd0, 3'd1, 3'd0};
        for (int c = 0; c < 7; c++) begin
            if (c < 3) tick(1'b1, d[c], s[c], r[c], 1'b0, 1'b0);
            else       tick(1'b0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
            exp_v = expected_vec();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL back_to_back cyc %0d: got %b expected %b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_fill_paused();
        for (int c = 0; c < 45; c++) begin
            if (c < 9) tick(1'b1, 2'($urandom), 2'($urandom), 3'($urandom_range(0, 2)), 1'b1, 1'b0);
            else       tick(1'b0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
            exp_v = expected_vec();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL fill_paused cyc %0d: got %b expected %b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_pause_mid_repeat();
        for (int c = 0; c < 11; c++) begin
            tick(c == 0, DIR_S, 2'd1, 3'd4, (c >= 3 && c < 6), 1'b0);
            exp_v = expected_vec();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL pause_mid_repeat cyc %0d: got %b expected %b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_issue();
        for (int c = 0; c < 12; c++) begin
            if (c < 6)       tick(1'b1, 2'($urandom), 2'($urandom), 3'd3, 1'b0, 1'b0);
            else if (c == 6) tick(1'b1, 2'b11, 2'b11, 3'd1, 1'b0, 1'b1);
            else             tick(c == 7, DIR_W_, 2'd2, 3'd1, 1'b0, 1'b0);
            exp_v = expected_vec();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL reset_mid_issue cyc %0d: got %b expected %b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick($urandom_range(0, 9) < 6, 2'($urandom), 2'($urandom), 3'($urandom),
                 $urandom_range(0, 9) < 2, $urandom_range(0, 99) == 0);
            exp_v = expected_vec();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL random cyc %0d: got %b expected %b", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        push_if.push_valid = 1'b0;
        push_if.push_dir   = 2'b00;
        push_if.push_step  = 2'b00;
        push_if.push_rep   = 3'd0;
        pause              = 1'b0;
        rst                = 1'b1;
        test_reset();
        test_single_move();
        test_back_to_back();
        test_fill_paused();
        test_pause_mid_repeat();
        test_reset_mid_issue();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/worm_cmd_seq.md
WORM_CMD_SEQ -- requirements
Module: worm_cmd_seq

Interface
REQ-001 The parameter list SHALL be: DEPTH, default 8, FIFO entries (power of two, 2..16).
REQ-002 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-003 Port `clk` SHALL be: input, 1 bit, rising-edge clock shared with the worm position stage.
REQ-004 Port `rst` SHALL be: input, 1 bit, synchronous active-high reset.
REQ-005 Port `push_valid` SHALL be: input, 1 bit, upstream offers a move.
REQ-006 Port `push_ready` SHALL be: output, 1 bit, the FIFO can accept a move.
REQ-007 Port `push_dir` SHALL be: input, 2 bits, move direction (00 N, 01 E, 10 S, 11 W).
REQ-008 Port `push_step` SHALL be: input, 2 bits, step size 0..3.
REQ-009 Port `push_rep` SHALL be: input, 3 bits, repeat count; the move is issued push_rep+1 times.
REQ-010 Port `pause` SHALL be: input, 1 bit, freeze issue.
REQ-011 Port `cmd_out` SHALL be: output, 4 bits, registered worm command {dir[1:0], step[1:0]}, which drives the worm `in` port directly.
REQ-012 Port `cmd_active` SHALL be: output, 1 bit, registered; 1 when cmd_out carries a queued move.
REQ-013 Port `fifo_count` SHALL be: output, 5 bits, entries stored in the FIFO, excluding the move being issued.

Function
REQ-014 Direction encoding SHALL be identity to worm format: dir[1] = subtract (S/W), dir[0] = axis (E/W → out2).
REQ-015 push_ready SHALL equal (fifo_count != DEPTH), combinationally, with no dependence on a same-cycle pop.
REQ-016 A push SHALL be accepted at a rising edge where push_valid && push_ready; the entry {dir,step,rep} is written at the tail.
REQ-017 Pushes with push_ready=0 SHALL be ignored; FIFO contents and fifo_count are unchanged.
REQ-018 State machine states SHALL be IDLE and ISSUE, with registers cur_cmd[3:0] and rem[2:0].
REQ-019 Each edge with pause=1 SHALL produce cmd_out<=0000 and cmd_active<=0; state, rem, cur_cmd and the FIFO head are held; pushes still accepted.
REQ-020 Each edge in ISSUE with rem!=0 and pause=0 SHALL produce cmd_out<=cur_cmd, cmd_active<=1, rem<=rem-1.
REQ-021 Each edge in IDLE, or in ISSUE with rem==0, with pause=0 and FIFO non-empty, SHALL pop the head and produce cmd_out<={dir,step}, cur_cmd<={dir,step}, rem<=rep, cmd_active<=1, state<=ISSUE.
REQ-022 The same condition as REQ-021 with the FIFO empty SHALL produce cmd_out<=0000 (worm no-op), cmd_active<=0, state<=IDLE.
REQ-023 Consecutive queued moves SHALL issue back-to-back with no idle cycle.
REQ-024 Latency SHALL be one cycle: a push accepted at edge k into an empty, idle, unpaused sequencer appears on cmd_out after edge k+1.
REQ-025 The FIFO SHALL not bypass: a push into an empty FIFO is not poppable at the same edge.
REQ-026 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 push_step=0 SHALL still be issued rep+1 times, with cmd_active=1.
REQ-029 Saturation SHALL not be handled by this block; it belongs downstream.

Reset
REQ-030 rst=1 at an edge SHALL produce fifo_count=0, pointers=0, state=IDLE, rem=0, cur_cmd=0, cmd_out=0000, cmd_active=0, push_ready=1.
REQ-031 Reset SHALL override push, pop and pause in the same cycle; an in-progress repeat and all queued moves are discarded.

Structure
REQ-032 The shared package SHALL hold the direction constants N/E/S/W, the widths DIR_W=2, STEP_W=2, REP_W=3, CMD_W=4, and the NOP command 4'b0000; the worm stage uses the same package.
REQ-033 The design SHALL have one sub-module, worm_cmd_fifo: a synchronous DEPTH×7-bit FIFO with push, pop, head, count and synchronous reset.
REQ-034 The sequencer FSM SHALL live in worm_cmd_seq.

Verification
REQ-035 Reset then idle -> cmd_out=0000, cmd_active=0, fifo_count=0, push_ready=1.
REQ-036 Push E/step3/rep2 at edge k -> cmd_out=0111 after edges k+1, k+2, k+3, then 0000.
REQ-037 Push N/1/rep0, S/2/rep1, W/3/rep0 on consecutive edges -> cmd_out sequence 0001, 1010, 1010, 1111, with no gap.
REQ-038 Push 9 entries while pause=1 with DEPTH=8 -> fifo_count=8, push_ready=0, ninth ignored; release pause -> 8 moves issue in push order.
REQ-039 Assert pause mid-repeat (rep=4, after 2 issues) for 3 cycles -> 3 cycles of 0000/cmd_active=0, then the remaining 3 issues.
REQ-040 rst during an ISSUE with 5 queued -> next cycle cmd_out=0000, fifo_count=0; a subsequent push issues normally.
